// File: rtl/if_stage.sv
// Instruction fetch: PC register, IMEM address drive and IF/ID capture (1-cycle fetch latency).
// Stall holds PC and IF/ID; flush bubbles IF/ID; redirect overrides stall. Optional IF_STAGE_PERF_EN adds counters.
module if_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_ADDR_W = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall_if,
  input  logic                   flush_if,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            pc,
  output logic                   if_id_valid,
  output logic [31:0]            if_id_instr,
  output logic [31:0]            if_id_pc,
  output logic [31:0]            if_id_pc_plus4,
`ifdef IF_STAGE_PERF_EN
  output logic [31:0]            perf_fetch_cnt,
  output logic [31:0]            perf_stall_cnt,
  output logic [31:0]            perf_flush_cnt,
`endif
  output logic                   misaligned_err
);

  logic [31:0] r_pc;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_pc_plus4;
  logic        r_misaligned;
  logic [31:0] w_pc_plus4;
  logic        w_load_if_id;

  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_load_if_id = !flush_if && !stall_if;

  // Redirect wins over stall so a taken branch is never lost behind a load-use hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_misaligned <= 1'b0;
    end else if (redirect_valid) begin
      r_pc <= {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) begin
        r_misaligned <= 1'b1;
      end
    end else if (!stall_if) begin
      r_pc <= w_pc_plus4;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush_if) begin
      r_valid       <= 1'b0;
      r_instr       <= 32'h0000_0000;
      r_id_pc       <= 32'h0000_0000;
      r_id_pc_plus4 <= 32'h0000_0000;
    end else if (!stall_if) begin
      r_valid       <= 1'b1;
      r_instr       <= imem_rdata;
      r_id_pc       <= r_pc;
      r_id_pc_plus4 <= w_pc_plus4;
    end
  end

  assign imem_addr      = r_pc[IMEM_ADDR_W+1:2];
  assign pc             = r_pc;
  assign if_id_valid    = r_valid;
  assign if_id_instr    = r_instr;
  assign if_id_pc       = r_id_pc;
  assign if_id_pc_plus4 = r_id_pc_plus4;
  assign misaligned_err = r_misaligned;

`ifdef IF_STAGE_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_cnt <= 32'h0000_0000;
      r_stall_cnt <= 32'h0000_0000;
      r_flush_cnt <= 32'h0000_0000;
    end else begin
      if (w_load_if_id && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (stall_if && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (flush_if && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_stall_cnt = r_stall_cnt;
  assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: hand-computed vector table, hand sequences, then random traffic vs a reference model.
module tb_if_stage;
  logic        clock = 1'b0;
  logic        reset, stall_if, flush_if, redirect_valid;
  logic [31:0] redirect_pc;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata, pc, if_id_instr, if_id_pc, if_id_pc_plus4;
  logic        if_id_valid, misaligned_err;
`ifdef IF_STAGE_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

  logic [31:0] mem [0:1023];
  assign imem_rdata = mem[imem_addr];

  always #5 clock = ~clock;

  if_stage #(.RESET_PC(32'h0000_0000), .IMEM_ADDR_W(10)) dut (
    .clock(clock), .reset(reset), .stall_if(stall_if), .flush_if(flush_if),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4),
`ifdef IF_STAGE_PERF_EN
    .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt),
`endif
    .misaligned_err(misaligned_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural state of the stage, advanced once per edge.
  logic [31:0] m_pc, m_instr, m_ipc, m_pp4, m_fc, m_sc, m_flc;
  logic        m_v, m_err;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_edge(input logic rst, st, fl, rv, input logic [31:0] rpc);
    logic [31:0] fetched;
    logic [31:0] idx;
    idx     = m_pc / 4 % 1024;
    fetched = mem[idx];
    if (rst) begin
      m_pc = 32'h0; m_v = 0; m_instr = 0; m_ipc = 0; m_pp4 = 0; m_err = 0;
      m_fc = 0; m_sc = 0; m_flc = 0;
    end else begin
      if (st) m_sc = sat_inc(m_sc);
      if (fl) m_flc = sat_inc(m_flc);
      if (fl) begin
        m_v = 0; m_instr = 0; m_ipc = 0; m_pp4 = 0;
      end else if (!st) begin
        m_fc = sat_inc(m_fc);
        m_v = 1; m_instr = fetched; m_ipc = m_pc; m_pp4 = m_pc + 32'd4;
      end
      if (rv) begin
        m_pc = rpc & 32'hFFFF_FFFC;
        if (rpc % 4 != 0) m_err = 1;
      end else if (!st) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic cycle(input logic rst, st, fl, rv, input logic [31:0] rpc);
    reset = rst; stall_if = st; flush_if = fl; redirect_valid = rv; redirect_pc = rpc;
    model_edge(rst, st, fl, rv, rpc);
    @(posedge clock);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [31:0] exp_addr;
    exp_addr = m_pc / 4 % 1024;
    chk({tag, " pc"}, pc, m_pc);
    chk({tag, " imem_addr"}, {22'd0, imem_addr}, exp_addr);
    chk({tag, " valid"}, {31'd0, if_id_valid}, {31'd0, m_v});
    chk({tag, " instr"}, if_id_instr, m_instr);
    chk({tag, " if_id_pc"}, if_id_pc, m_ipc);
    chk({tag, " pc_plus4"}, if_id_pc_plus4, m_pp4);
    chk({tag, " misaligned"}, {31'd0, misaligned_err}, {31'd0, m_err});
`ifdef IF_STAGE_PERF_EN
    chk({tag, " fetch_cnt"}, perf_fetch_cnt, m_fc);
    chk({tag, " stall_cnt"}, perf_stall_cnt, m_sc);
    chk({tag, " flush_cnt"}, perf_flush_cnt, m_flc);
`endif
  endtask

  typedef struct {
    logic        rst, st, fl, rv;
    logic [31:0] rpc, pc, instr, ipc, pp4;
    logic        v, err;
  } vec_t;

  vec_t tv [19];

  initial begin
    reset = 1; stall_if = 0; flush_if = 0; redirect_valid = 0; redirect_pc = 0;
    m_pc = 0; m_v = 0; m_instr = 0; m_ipc = 0; m_pp4 = 0; m_err = 0;
    m_fc = 0; m_sc = 0; m_flc = 0;
    for (int i = 0; i < 1024; i++) mem[i] = {16'hC0DE, i[15:0]};
    mem[0] = 32'h2010_0009; mem[1] = 32'h2011_0003; mem[2] = 32'h0211_8020; mem[3] = 32'h0;

    //           rst st fl rv rpc            pc             instr          ipc            pp4            v  err
    tv[0]  = '{1, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         0, 0};
    tv[1]  = '{1, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         0, 0};
    tv[2]  = '{0, 0, 0, 0, 32'h0,         32'h4,         32'h2010_0009, 32'h0,         32'h4,         1, 0};
    tv[3]  = '{0, 0, 0, 0, 32'h0,         32'h8,         32'h2011_0003, 32'h4,         32'h8,         1, 0};
    tv[4]  = '{0, 1, 0, 0, 32'h0,         32'h8,         32'h2011_0003, 32'h4,         32'h8,         1, 0};
    tv[5]  = '{0, 1, 0, 0, 32'h0,         32'h8,         32'h2011_0003, 32'h4,         32'h8,         1, 0};
    tv[6]  = '{0, 1, 0, 0, 32'h0,         32'h8,         32'h2011_0003, 32'h4,         32'h8,         1, 0};
    tv[7]  = '{0, 0, 0, 0, 32'h0,         32'hC,         32'h0211_8020, 32'h8,         32'hC,         1, 0};
    tv[8]  = '{0, 0, 1, 1, 32'h40,        32'h40,        32'h0,         32'h0,         32'h0,         0, 0};
    tv[9]  = '{0, 0, 0, 0, 32'h0,         32'h44,        32'hC0DE_0010, 32'h40,        32'h44,        1, 0};
    tv[10] = '{0, 1, 1, 0, 32'h0,         32'h44,        32'h0,         32'h0,         32'h0,         0, 0};
    tv[11] = '{0, 0, 0, 0, 32'h0,         32'h48,        32'hC0DE_0011, 32'h44,        32'h48,        1, 0};
    tv[12] = '{0, 1, 0, 1, 32'h100,       32'h100,       32'hC0DE_0011, 32'h44,        32'h48,        1, 0};
    tv[13] = '{0, 0, 0, 0, 32'h0,         32'h104,       32'hC0DE_0040, 32'h100,       32'h104,       1, 0};
    tv[14] = '{0, 0, 0, 1, 32'h46,        32'h44,        32'hC0DE_0041, 32'h104,       32'h108,       1, 1};
    tv[15] = '{0, 0, 0, 0, 32'h0,         32'h48,        32'hC0DE_0011, 32'h44,        32'h48,        1, 1};
    tv[16] = '{0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hC0DE_0012, 32'h48,        32'h4C,        1, 1};
    tv[17] = '{0, 0, 0, 0, 32'h0,         32'h0,         32'hC0DE_03FF, 32'hFFFF_FFFC, 32'h0,         1, 1};
    tv[18] = '{1, 1, 0, 1, 32'h200,       32'h0,         32'h0,         32'h0,         32'h0,         0, 0};

    for (int i = 0; i < 19; i++) begin
      cycle(tv[i].rst, tv[i].st, tv[i].fl, tv[i].rv, tv[i].rpc);
      chk($sformatf("v%0d pc", i), pc, tv[i].pc);
      chk($sformatf("v%0d imem_addr", i), {22'd0, imem_addr}, {22'd0, tv[i].pc[11:2]});
      chk($sformatf("v%0d valid", i), {31'd0, if_id_valid}, {31'd0, tv[i].v});
      chk($sformatf("v%0d instr", i), if_id_instr, tv[i].instr);
      chk($sformatf("v%0d if_id_pc", i), if_id_pc, tv[i].ipc);
      chk($sformatf("v%0d pc_plus4", i), if_id_pc_plus4, tv[i].pp4);
      chk($sformatf("v%0d misaligned", i), {31'd0, misaligned_err}, {31'd0, tv[i].err});
`ifdef IF_STAGE_PERF_EN
      if (i == 6) chk("stall3 stall_cnt", perf_stall_cnt, 32'd3);
      if (i == 18) begin
        chk("rst fetch_cnt", perf_fetch_cnt, 32'd0);
        chk("rst stall_cnt", perf_stall_cnt, 32'd0);
        chk("rst flush_cnt", perf_flush_cnt, 32'd0);
      end
`endif
    end

    // Reset landing in the middle of a multi-cycle stall with a redirect pending.
    cycle(0, 0, 0, 0, 32'h0);
    cycle(0, 0, 0, 1, 32'h0000_0023);
    cycle(0, 1, 0, 0, 32'h0);
    cycle(0, 1, 0, 0, 32'h0);
    check_model("seq_pre");
    cycle(1, 1, 1, 1, 32'h0000_0301);
    check_model("seq_rst");
    cycle(0, 0, 0, 0, 32'h0);
    check_model("seq_post");

    // Random traffic against the reference model.
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    for (int n = 0; n < 400; n++) begin
      logic        r, s, f, v;
      logic [31:0] t;
      r = ($urandom_range(0, 49) == 0);
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 7) == 0);
      v = ($urandom_range(0, 7) == 0);
      t = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 32'h1FFF);
      cycle(r, s, f, v, t);
      check_model($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the decode/register-read logic of the MIPS `cpu` core.
- Owns the program counter and drives the word address into the instruction memory (`cpu_IMem`, combinational read).
- Captures the returned word into the IF/ID pipeline register.
- Handles stall, flush and branch/jump redirect requests coming from ID/EX.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- IMEM_ADDR_W, 10, word-address width of the instruction memory. The byte PC maps to word index pc[IMEM_ADDR_W+1:2].

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall_if  input  1  hold PC and IF/ID contents (load-use hazard from ID).
- flush_if  input  1  replace the IF/ID contents with a bubble on this edge.
- redirect_valid  input  1  load PC from redirect_pc on this edge (taken branch or jump).
- redirect_pc  input  32  redirect target byte address.
- imem_addr  output  IMEM_ADDR_W  word address to instruction memory; equals pc[IMEM_ADDR_W+1:2].
- imem_rdata  input  32  instruction word; valid in the same cycle as imem_addr.
- pc  output  32  current fetch PC.
- if_id_valid  output  1  IF/ID register holds a real instruction.
- if_id_instr  output  32  fetched instruction; 32'h0000_0000 (NOP) when not valid.
- if_id_pc  output  32  PC of if_id_instr.
- if_id_pc_plus4  output  32  if_id_pc + 4.
- misaligned_err  output  1  sticky flag: a redirect target had non-zero bits [1:0].

Behaviour:
Reset:
- On a rising edge with reset=1: pc=RESET_PC, if_id_valid=0, if_id_instr=0, if_id_pc=0, if_id_pc_plus4=0, misaligned_err=0.
- Reset overrides every other input, including a reset asserted mid-stall or mid-redirect.

Datapath:
- No internal state machine: the PC register and IF/ID register are updated every edge according to the priority rules below.
- Fetch latency is 1 cycle. Instruction at pc appears on if_id_instr after the next edge.
- Adder is 32-bit modulo: pc=32'hFFFF_FFFC advances to 32'h0000_0000 with no error.
- imem_addr simply truncates, so PCs beyond the memory size alias.

PC update priority (highest first):
1. reset
2. redirect_valid=1: pc <= {redirect_pc[31:2],2'b00}, even if stall_if=1. If redirect_pc[1:0]!=0, misaligned_err <= 1 (sticky until reset).
3. stall_if=1: pc holds.
4. otherwise: pc <= pc + 4.

IF/ID update priority (highest first):
1. reset
2. flush_if=1: bubble, i.e. valid=0, instr=0, pc=0, pc_plus4=0. Applies even if stall_if=1.
3. stall_if=1: hold all four fields.
4. otherwise: valid=1, instr=imem_rdata, if_id_pc=pc, if_id_pc_plus4=pc+4.

Simultaneous events:
- redirect_valid without flush_if: the sequentially fetched word still enters IF/ID. Delay-slot semantics are the upstream controller's choice; the stage does not infer a flush.
- stall_if+flush_if: PC holds, IF/ID becomes a bubble.
- stall_if+redirect_valid: PC redirects, IF/ID holds.

Output timing: all outputs are registered except imem_addr, which is combinational from pc.

Optional Feature:
Macro: IF_STAGE_PERF_EN

Defined:
- Adds three 32-bit output ports, all cleared on reset and saturating at 32'hFFFF_FFFF (no wrap):
  - perf_fetch_cnt: increments each edge where IF/ID loads a valid instruction (case 4).
  - perf_stall_cnt: increments each edge with stall_if=1 and reset=0.
  - perf_flush_cnt: increments each edge with flush_if=1 and reset=0.
- A cycle with stall_if=1 and flush_if=1 increments both stall and flush counters.

Undefined:
- Ports and counters are absent.
- All other behaviour is identical.

Test Plan:
1. Reset then run: RESET_PC=0, memory words 0..3 = 20100009, 20110003, 02118020, 00000000; hold reset for 2 edges, then release. Required: if_id_instr sequence 20100009, 20110003, 02118020 with if_id_pc 0, 4, 8 and if_id_pc_plus4 4, 8, 12; if_id_valid=0 until the first post-reset edge.
2. Stall: with pc=8, assert stall_if for 3 cycles. Required: pc stays 8, IF/ID holds the instruction from pc=4, and the next fetch after release is pc=8. With IF_STAGE_PERF_EN, perf_stall_cnt=3.
3. Redirect+flush: at pc=12, assert redirect_valid with redirect_pc=32'h40 and flush_if in the same cycle. Required next edge: pc=32'h40, if_id_valid=0, if_id_instr=0. The following edge gives if_id_pc=32'h40.
4. Stall+flush and stall+redirect in the same cycle:
   - stall+flush: pc holds and IF/ID becomes a bubble.
   - stall+redirect_pc=32'h100: pc=32'h100 and IF/ID holds.
5. Misaligned redirect and wrap:
   - redirect_pc=32'h0000_0046 gives pc=32'h44 and misaligned_err=1, which stays 1 until reset.
   - A redirect to 32'hFFFF_FFFC followed by one free-running edge gives pc=0 with misaligned_err unchanged.
6. Reset mid-operation: assert reset during an active stall and redirect. Required on that edge: pc=RESET_PC, all IF/ID fields 0, misaligned_err=0, and perf counters 0 when enabled.
